multicycle_control: RTL and testbench

Sequencing controller for the kianv Harris-style multicycle rv32i core. It decodes the instruction held in the instruction register and drives one control word per cycle to the shared datapath: ALU, immediate extender, register file, PC and the memory port. It steps each instruction through fetch, decode, execute, memory and writeback states, and stalls on the memory handshake. It sits between the instruction register and the datapath multiplexers, and is the only source of `immsrc`.

---
 rtl/multicycle_control_pkg.sv | 59 +++++
 rtl/multicycle_control_if.sv | 17 +
 rtl/multicycle_control_alu_decoder.sv | 40 ++++
 rtl/multicycle_control_fsm.sv | 178 +++++++++++++++++
 rtl/multicycle_control.sv | 60 ++++++
 tb/tb_multicycle_control.sv | 237 +++++++++++++++++++++++
 6 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared opcode, ALU-operation and immediate-format codes for the
// multicycle rv32i sequencing controller.
package multicycle_control_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] IMMSRC_I = 3'd0;
    localparam logic [2:0] IMMSRC_S = 3'd1;
    localparam logic [2:0] IMMSRC_B = 3'd2;
    localparam logic [2:0] IMMSRC_J = 3'd3;
    localparam logic [2:0] IMMSRC_U = 3'd4;

    typedef enum logic [2:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_R,
        ALUOP_I,
        ALUOP_PASSB
    } aluop_e;

    function automatic logic [2:0] immsrc_of(input logic [6:0] op);
        unique case (op)
            OP_STORE:          return IMMSRC_S;
            OP_BRANCH:         return IMMSRC_B;
            OP_JAL:            return IMMSRC_J;
            OP_LUI, OP_AUIPC:  return IMMSRC_U;
            default:           return IMMSRC_I;
        endcase
    endfunction

    function automatic logic op_known(input logic [6:0] op);
        unique case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Memory-port handshake between the controller and the memory unit.
interface multicycle_control_if;
    logic mem_valid;
    logic mem_we;
    logic adr_src;
    logic mem_ready;

    modport master (
        output mem_valid, mem_we, adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_valid, mem_we, adr_src,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Maps the opcode class chosen by the FSM plus funct3/funct7b5
// onto a concrete ALU operation.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  aluop_e     aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alucontrol
);

    logic is_r;

    assign is_r = (aluop == ALUOP_R);

    always_comb begin
        alucontrol = ALU_ADD;
        unique case (aluop)
            ALUOP_ADD:   alucontrol = ALU_ADD;
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_PASSB: alucontrol = ALU_PASSB;
            ALUOP_R, ALUOP_I: begin
                // funct7b5 of an I-type is immediate bit 10: only
                // meaningful for the shift-right pair
                unique case (funct3)
                    3'b000: alucontrol = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: alucontrol = ALU_SLL;
                    3'b010: alucontrol = ALU_SLT;
                    3'b011: alucontrol = ALU_SLTU;
                    3'b100: alucontrol = ALU_XOR;
                    3'b101: alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: alucontrol = ALU_OR;
                    default: alucontrol = ALU_AND;
                endcase
            end
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Instruction sequencer: one control word per state, stalls on the
// memory handshake.
module multicycle_control_fsm
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       mem_ready,
    output logic       mem_valid,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output aluop_e     aluop,
    output logic       illegal_instr,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH,
        S_JAL, S_JALR, S_LUI, S_AUIPC
    } state_e;

    state_e state_q, state_d;
    logic   br_taken, br_bad;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_JALR, S_LUI, S_AUIPC:
                        state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        br_bad   = 1'b0;
        unique case (funct3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = !alu_zero;
            3'b100:  br_taken = alu_lt;
            3'b101:  br_taken = !alu_lt;
            3'b110:  br_taken = alu_ltu;
            3'b111:  br_taken = !alu_ltu;
            default: br_bad   = 1'b1;
        endcase
    end

    always_comb begin
        mem_valid     = 1'b0;
        mem_we        = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alusrca       = 2'd0;
        alusrcb       = 2'd0;
        resultsrc     = 2'd0;
        aluop         = ALUOP_ADD;
        illegal_instr = 1'b0;
        instr_done    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_valid = 1'b1;
                alusrcb   = 2'd2;
                resultsrc = 2'd2;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alusrca       = 2'd1;
                alusrcb       = 2'd1;
                illegal_instr = !op_known(op);
            end
            S_MEMADR: begin
                alusrca = 2'd2;
                alusrcb = 2'd1;
            end
            S_MEMREAD: begin
                mem_valid = 1'b1;
                adr_src   = 1'b1;
            end
            S_MEMWB: begin
                resultsrc  = 2'd1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_valid  = 1'b1;
                mem_we     = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECR: begin
                alusrca = 2'd2;
                aluop   = ALUOP_R;
            end
            S_EXECI: begin
                alusrca = 2'd2;
                alusrcb = 2'd1;
                aluop   = ALUOP_I;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca       = 2'd2;
                aluop         = ALUOP_SUB;
                pc_write      = br_taken;
                illegal_instr = br_bad;
                instr_done    = 1'b1;
            end
            S_JAL: begin
                // target came from DECODE; ALU now forms old PC + 4 for rd
                alusrca  = 2'd1;
                alusrcb  = 2'd2;
                pc_write = 1'b1;
            end
            S_JALR: begin
                alusrca   = 2'd2;
                alusrcb   = 2'd1;
                resultsrc = 2'd2;
                pc_write  = 1'b1;
            end
            S_LUI: begin
                alusrcb = 2'd1;
                aluop   = ALUOP_PASSB;
            end
            S_AUIPC: begin
                alusrca = 2'd1;
                alusrcb = 2'd1;
            end
            default: ;
        endcase
        // reset must kill a pending request without waiting for a clock
        if (!resetn) begin
            mem_valid = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle rv32i controller top: FSM, ALU decoder and immsrc decode.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [6:0]                  op,
    input  logic [2:0]                  funct3,
    input  logic                        funct7b5,
    input  logic                        alu_zero,
    input  logic                        alu_lt,
    input  logic                        alu_ltu,
    multicycle_control_if.master        mem,
    output logic                        ir_write,
    output logic                        pc_write,
    output logic                        reg_write,
    output logic [1:0]                  alusrca,
    output logic [1:0]                  alusrcb,
    output logic [1:0]                  resultsrc,
    output logic [2:0]                  immsrc,
    output logic [3:0]                  alucontrol,
    output logic                        illegal_instr,
    output logic                        instr_done
);

    aluop_e aluop;

    assign immsrc = immsrc_of(op);

    multicycle_control_fsm u_fsm (
        .clk           (clk),
        .resetn        (resetn),
        .op            (op),
        .funct3        (funct3),
        .alu_zero      (alu_zero),
        .alu_lt        (alu_lt),
        .alu_ltu       (alu_ltu),
        .mem_ready     (mem.mem_ready),
        .mem_valid     (mem.mem_valid),
        .mem_we        (mem.mem_we),
        .adr_src       (mem.adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alusrca       (alusrca),
        .alusrcb       (alusrcb),
        .resultsrc     (resultsrc),
        .aluop         (aluop),
        .illegal_instr (illegal_instr),
        .instr_done    (instr_done)
    );

    alu_decoder u_alu_dec (
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction vector table
// plus wait-state and reset-during-store sequences.
module tb_multicycle_control;

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_I      = 7'b0010011;
    localparam logic [6:0] T_BR     = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [6:0] op = T_I;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       alu_zero = 1'b0;
    logic       alu_lt = 1'b0;
    logic       alu_ltu = 1'b0;
    logic       ir_write, pc_write, reg_write;
    logic [1:0] alusrca, alusrcb, resultsrc;
    logic [2:0] immsrc;
    logic [3:0] alucontrol;
    logic       illegal_instr, instr_done;

    int errors = 0;
    int checks = 0;

    multicycle_control_if mif ();

    multicycle_control dut (
        .clk           (clk),
        .resetn        (resetn),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .alu_zero      (alu_zero),
        .alu_lt        (alu_lt),
        .alu_ltu       (alu_ltu),
        .mem           (mif),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alusrca       (alusrca),
        .alusrcb       (alusrcb),
        .resultsrc     (resultsrc),
        .immsrc        (immsrc),
        .alucontrol    (alucontrol),
        .illegal_instr (illegal_instr),
        .instr_done    (instr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, lt, ltu;
        int         cyc, alu, imm;
        int         nreg, npc, nmem, nill, ndone;
        int         pcsrc, wbsrc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc = 0, alu = -1, imm = -1, fetch_ok = 0;
        int nreg = 0, npc = 0, nmem = 0, nill = 0, ndone = 0;
        int pcsrc = -1, wbsrc = -1;
        bit done = 0;
        op = v.op; funct3 = v.f3; funct7b5 = v.f7;
        alu_zero = v.z; alu_lt = v.lt; alu_ltu = v.ltu;
        mif.mem_ready = 1'b1;
        for (int c = 1; c <= 16 && !done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                imm = int'(immsrc);
                fetch_ok = int'(mif.mem_valid && ir_write);
            end
            if (c == 3) alu = int'(alucontrol);
            nreg  += int'(reg_write);
            npc   += int'(pc_write);
            nmem  += int'(mif.mem_valid);
            nill  += int'(illegal_instr);
            ndone += int'(instr_done);
            if (c > 1 && pc_write) pcsrc = int'(resultsrc);
            if (reg_write) wbsrc = int'(resultsrc);
            if (instr_done || illegal_instr) begin
                done = 1;
                cyc = c;
            end
            step();
        end
        chk({v.name, " fetch"}, fetch_ok, 1);
        chk({v.name, " cycles"}, cyc, v.cyc);
        if (v.cyc >= 3) chk({v.name, " alucontrol"}, alu, v.alu);
        chk({v.name, " immsrc"}, imm, v.imm);
        chk({v.name, " reg_write"}, nreg, v.nreg);
        chk({v.name, " pc_write"}, npc, v.npc);
        chk({v.name, " mem_valid"}, nmem, v.nmem);
        chk({v.name, " illegal"}, nill, v.nill);
        chk({v.name, " done"}, ndone, v.ndone);
        chk({v.name, " pc_src"}, pcsrc, v.pcsrc);
        chk({v.name, " wb_src"}, wbsrc, v.wbsrc);
    endtask

    initial begin
        // name op f3 f7 z lt ltu | cyc alu imm reg pc mem ill done pcsrc wbsrc
        vecs.push_back('{"addi",    T_I, 3'b000,1,0,0,0, 4, 0,0, 1,1,1,0,1, -1, 0});
        vecs.push_back('{"addi_f7", T_I, 3'b000,1,0,0,0, 4, 0,0, 1,1,1,0,1, -1, 0});
        vecs.push_back('{"srai",    T_I, 3'b101,1,0,0,0, 4, 7,0, 1,1,1,0,1, -1, 0});
        vecs.push_back('{"srli",    T_I, 3'b101,0,0,0,0, 4, 6,0, 1,1,1,0,1, -1, 0});
        vecs.push_back('{"sltiu",   T_I, 3'b011,0,0,0,0, 4, 4,0, 1,1,1,0,1, -1, 0});
        vecs.push_back('{"sub",     T_R, 3'b000,1,0,0,0, 4, 1,0, 1,1,1,0,1, -1, 0});
        vecs.push_back('{"add",     T_R, 3'b000,0,0,0,0, 4, 0,0, 1,1,1,0,1, -1, 0});
        vecs.push_back('{"sll",     T_R, 3'b001,0,0,0,0, 4, 2,0, 1,1,1,0,1, -1, 0});
        vecs.push_back('{"slt",     T_R, 3'b010,0,0,0,0, 4, 3,0, 1,1,1,0,1, -1, 0});
        vecs.push_back('{"xor",     T_R, 3'b100,0,0,0,0, 4, 5,0, 1,1,1,0,1, -1, 0});
        vecs.push_back('{"sra",     T_R, 3'b101,1,0,0,0, 4, 7,0, 1,1,1,0,1, -1, 0});
        vecs.push_back('{"or",      T_R, 3'b110,0,0,0,0, 4, 8,0, 1,1,1,0,1, -1, 0});
        vecs.push_back('{"and",     T_R, 3'b111,0,0,0,0, 4, 9,0, 1,1,1,0,1, -1, 0});
        vecs.push_back('{"lui",     T_LUI,3'b000,0,0,0,0,4,10,4, 1,1,1,0,1, -1, 0});
        vecs.push_back('{"auipc",   T_AUIPC,3'b000,0,0,0,0,4,0,4,1,1,1,0,1, -1, 0});
        vecs.push_back('{"jal",     T_JAL,3'b000,0,0,0,0,4, 0,3, 1,2,1,0,1,  0, 0});
        vecs.push_back('{"jalr",    T_JALR,3'b000,0,0,0,0,4,0,0, 1,2,1,0,1,  2, 0});
        vecs.push_back('{"lw",      T_LOAD,3'b010,0,0,0,0,5,0,0, 1,1,2,0,1, -1, 1});
        vecs.push_back('{"sw",      T_STORE,3'b010,0,0,0,0,4,0,1,0,1,2,0,1, -1,-1});
        vecs.push_back('{"beq_t",   T_BR,3'b000,0,1,0,0, 3, 1,2, 0,2,1,0,1,  0,-1});
        vecs.push_back('{"bne_nt",  T_BR,3'b001,0,1,0,0, 3, 1,2, 0,1,1,0,1, -1,-1});
        vecs.push_back('{"blt_t",   T_BR,3'b100,0,0,1,0, 3, 1,2, 0,2,1,0,1,  0,-1});
        vecs.push_back('{"bge_nt",  T_BR,3'b101,0,0,1,0, 3, 1,2, 0,1,1,0,1, -1,-1});
        vecs.push_back('{"bltu_t",  T_BR,3'b110,0,0,0,1, 3, 1,2, 0,2,1,0,1,  0,-1});
        vecs.push_back('{"bltu_nt", T_BR,3'b110,0,1,1,0, 3, 1,2, 0,1,1,0,1, -1,-1});
        vecs.push_back('{"bgeu_t",  T_BR,3'b111,0,1,1,0, 3, 1,2, 0,2,1,0,1,  0,-1});
        vecs.push_back('{"br_f3bad",T_BR,3'b010,0,1,1,1, 3, 1,2, 0,1,1,1,1, -1,-1});
        vecs.push_back('{"ill_7f",  7'h7f,3'b000,0,0,0,0,2, 0,0, 0,1,1,1,0, -1,-1});
        vecs.push_back('{"ill_00",  7'h00,3'b000,0,0,0,0,2, 0,0, 0,1,1,1,0, -1,-1});
        vecs.push_back('{"addi2",   T_I, 3'b110,0,0,0,0, 4, 8,0, 1,1,1,0,1, -1, 0});

        // reset: FETCH word present but enables masked
        mif.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst mem_valid", int'(mif.mem_valid), 0);
        chk("rst ir_write", int'(ir_write), 0);
        chk("rst pc_write", int'(pc_write), 0);
        chk("rst reg_write", int'(reg_write), 0);
        chk("rst instr_done", int'(instr_done), 0);
        chk("rst alusrcb", int'(alusrcb), 2);
        chk("rst resultsrc", int'(resultsrc), 2);
        @(posedge clk);
        #1 resetn = 1'b1;
        #1 chk("rel mem_valid", int'(mif.mem_valid), 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // load with a stalled fetch and three MEMREAD wait states
        op = T_LOAD; funct3 = 3'b010; funct7b5 = 1'b0;
        mif.mem_ready = 1'b0;
        @(negedge clk);
        chk("ldw fetch hold valid", int'(mif.mem_valid), 1);
        chk("ldw fetch hold irw", int'(ir_write), 0);
        chk("ldw fetch hold pcw", int'(pc_write), 0);
        step();
        mif.mem_ready = 1'b1;
        @(negedge clk);
        chk("ldw fetch irw", int'(ir_write), 1);
        step();
        mif.mem_ready = 1'b0;
        @(negedge clk);
        chk("ldw decode valid", int'(mif.mem_valid), 0);
        step();
        @(negedge clk);
        chk("ldw memadr srca", int'(alusrca), 2);
        chk("ldw memadr srcb", int'(alusrcb), 1);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mif.mem_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("ldw memread req %0d", i),
                int'(mif.mem_valid && mif.adr_src && !mif.mem_we), 1);
            chk($sformatf("ldw memread rw %0d", i), int'(reg_write), 0);
            step();
        end
        @(negedge clk);
        chk("ldw memwb reg_write", int'(reg_write), 1);
        chk("ldw memwb resultsrc", int'(resultsrc), 1);
        chk("ldw memwb done", int'(instr_done), 1);
        chk("ldw memwb valid", int'(mif.mem_valid), 0);
        step();

        // store stalled in MEMWRITE, then reset mid-transfer
        op = T_STORE; funct3 = 3'b010;
        mif.mem_ready = 1'b1;
        @(negedge clk);
        chk("st fetch valid", int'(mif.mem_valid), 1);
        step();
        step();
        mif.mem_ready = 1'b0;
        step();
        @(negedge clk);
        chk("st wait valid", int'(mif.mem_valid), 1);
        chk("st wait we", int'(mif.mem_we), 1);
        chk("st wait done", int'(instr_done), 0);
        step();
        #3 resetn = 1'b0;
        #1;
        chk("st rst valid", int'(mif.mem_valid), 0);
        chk("st rst we", int'(mif.mem_we), 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        chk("st rel valid", int'(mif.mem_valid), 1);
        chk("st rel we", int'(mif.mem_we), 0);
        chk("st rel adr_src", int'(mif.adr_src), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
